// File: rtl/enemy_chase.sv
// enemy_chase: per-enemy pursuit controller (position, HP, stun, death, melee attack).
// Define ENEMY_DIAGONAL_EN to step both axes on every move tick instead of only the dominant one.
module enemy_chase #(
    parameter int SPEED       = 1,
    parameter int MOVE_DIV    = 2,
    parameter int STOP_DIST   = 8,
    parameter int HP_INIT     = 3,
    parameter int STUN_FRAMES = 8,
    parameter int DIE_FRAMES  = 16,
    parameter int ATK_FRAMES  = 30,
    parameter int X_MAX       = 319,
    parameter int Y_MAX       = 239
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       Spawn,
    input  logic [8:0] Spawn_X,
    input  logic [8:0] Spawn_Y,
    input  logic [8:0] Player_X,
    input  logic [8:0] Player_Y,
    input  logic       Hit,
    output logic [8:0] Obj_X_Pos,
    output logic [8:0] Obj_Y_Pos,
    output logic [8:0] Obj_X_Motion,
    output logic [8:0] Obj_Y_Motion,
    output logic [1:0] Obj_Dir,
    output logic       Alive,
    output logic       Dying,
    output logic       Attack
);
    localparam int MAX_AD = (ATK_FRAMES > DIE_FRAMES) ? ATK_FRAMES : DIE_FRAMES;
    localparam int MAX_FRAMES = (MAX_AD > STUN_FRAMES) ? MAX_AD : STUN_FRAMES;
    localparam int CW = $clog2(MAX_FRAMES + 1);
    localparam logic [9:0] SPD = 10'(SPEED);
    localparam logic [9:0] STOP = 10'(STOP_DIST);
    localparam logic signed [11:0] X_LIM = 12'(X_MAX);
    localparam logic signed [11:0] Y_LIM = 12'(Y_MAX);

    typedef enum logic [2:0] {IDLE, CHASE, ATTACK, STUN, DYING} state_t;

    state_t        state_q, state_d;
    logic          frame_clk_q;
    logic [3:0]    div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    hp_q, hp_d;
    logic [8:0]    x_q, x_d, y_q, y_d;
    logic [8:0]    mx_q, mx_d, my_q, my_d;
    logic [1:0]    dir_q, dir_d;
    logic          attack_q, attack_d;

    logic              frame_tick, move_tick, in_range, x_dom, alive;
    logic signed [9:0] dx, dy;
    logic [9:0]        adx, ady, sx, sy, ux, uy;
    logic [8:0]        nx, ny;
    logic [1:0]        ndir;

    // Moves pos by mag toward the sign given, saturating to [0, lim].
    function automatic logic [8:0] step_axis(input logic [8:0] pos, input logic neg,
                                             input logic [9:0] mag, input logic signed [11:0] lim);
        logic signed [11:0] n;
        n = neg ? $signed({3'b000, pos}) - $signed({2'b00, mag})
                : $signed({3'b000, pos}) + $signed({2'b00, mag});
        return (n < 12'sd0) ? 9'd0 : (n > lim) ? lim[8:0] : n[8:0];
    endfunction

    assign frame_tick = frame_clk & ~frame_clk_q;
    assign move_tick  = frame_tick && (div_q == 4'(MOVE_DIV - 1));
    assign dx         = $signed({1'b0, Player_X}) - $signed({1'b0, x_q});
    assign dy         = $signed({1'b0, Player_Y}) - $signed({1'b0, y_q});
    assign adx        = dx[9] ? -dx : dx;
    assign ady        = dy[9] ? -dy : dy;
    assign sx         = (adx < SPD) ? adx : SPD;
    assign sy         = (ady < SPD) ? ady : SPD;
    assign in_range   = (adx <= STOP) && (ady <= STOP);
    assign x_dom      = adx >= ady;
`ifdef ENEMY_DIAGONAL_EN
    assign ux = sx;
    assign uy = sy;
`else
    assign ux = x_dom ? sx : 10'd0;
    assign uy = x_dom ? 10'd0 : sy;
`endif
    assign nx    = step_axis(x_q, dx[9], ux, X_LIM);
    assign ny    = step_axis(y_q, dy[9], uy, Y_LIM);
    assign ndir  = x_dom ? (dx[9] ? 2'd2 : 2'd3) : (dy[9] ? 2'd0 : 2'd1);
    assign alive = (state_q == CHASE) || (state_q == ATTACK) || (state_q == STUN);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        hp_d     = hp_q;
        x_d      = x_q;
        y_d      = y_q;
        mx_d     = mx_q;
        my_d     = my_q;
        dir_d    = dir_q;
        attack_d = 1'b0;
        if (frame_tick)
            div_d = move_tick ? 4'd0 : div_q + 4'd1;
        if (Spawn) begin
            state_d = CHASE;
            x_d     = Spawn_X;
            y_d     = Spawn_Y;
            hp_d    = 3'(HP_INIT);
            mx_d    = 9'd0;
            my_d    = 9'd0;
            cnt_d   = '0;
            div_d   = 4'd0;
        end else if (Hit && alive) begin
            hp_d    = hp_q - 3'd1;
            state_d = (hp_q == 3'd1) ? DYING : STUN;
            cnt_d   = '0;
            mx_d    = 9'd0;
            my_d    = 9'd0;
        end else begin
            case (state_q)
                CHASE: if (move_tick) begin
                    if (in_range) begin
                        state_d  = ATTACK;
                        attack_d = 1'b1;
                        cnt_d    = '0;
                        mx_d     = 9'd0;
                        my_d     = 9'd0;
                    end else begin
                        x_d   = nx;
                        y_d   = ny;
                        mx_d  = nx - x_q;
                        my_d  = ny - y_q;
                        dir_d = ndir;
                    end
                end
                ATTACK: if (move_tick && !in_range) begin
                    state_d = CHASE;
                end else if (frame_tick) begin
                    attack_d = cnt_q == CW'(ATK_FRAMES - 1);
                    cnt_d    = attack_d ? '0 : cnt_q + 1'b1;
                end
                STUN: if (frame_tick) begin
                    state_d = (cnt_q == CW'(STUN_FRAMES - 1)) ? CHASE : STUN;
                    cnt_d   = cnt_q + 1'b1;
                end
                DYING: if (frame_tick) begin
                    state_d = (cnt_q == CW'(DIE_FRAMES - 1)) ? IDLE : DYING;
                    cnt_d   = cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            frame_clk_q <= 1'b0;
            div_q       <= 4'd0;
            cnt_q       <= '0;
            hp_q        <= 3'd0;
            x_q         <= 9'd0;
            y_q         <= 9'd0;
            mx_q        <= 9'd0;
            my_q        <= 9'd0;
            dir_q       <= 2'd1;
            attack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_clk_q <= frame_clk;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            hp_q        <= hp_d;
            x_q         <= x_d;
            y_q         <= y_d;
            mx_q        <= mx_d;
            my_q        <= my_d;
            dir_q       <= dir_d;
            attack_q    <= attack_d;
        end
    end

    assign Obj_X_Pos    = x_q;
    assign Obj_Y_Pos    = y_q;
    assign Obj_X_Motion = mx_q;
    assign Obj_Y_Motion = my_q;
    assign Obj_Dir      = dir_q;
    assign Alive        = alive;
    assign Dying        = state_q == DYING;
    assign Attack       = attack_q;
endmodule
